// File: rtl/mul_pkg.sv
// Shared definitions for the sequential mantissa multiplier.
//   mul_state_t : controller states (IDLE, RUN, DONE)
//   NIB_W       : nibble width; also the ROM operand width
//   nib_count() : number of nibbles per operand for a given width
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/rom256X8.sv
// 256x8 nibble-product table: data = addr[7:4] * addr[3:0].
// Combinational read, so the data is valid in the same cycle as the address.
//   addr : {a_nibble, b_nibble}
//   data : 8-bit product of the two nibbles
module rom256X8 (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  assign data = {4'b0000, addr[7:4]} * {4'b0000, addr[3:0]};

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential unsigned mantissa multiplier. Walks every nibble pair (i, j) of
// the two operands through an external 4x4 product ROM and accumulates
// rom_data << 4*(i+j) into a 2*WIDTH accumulator. One pair per cycle, so an
// operation takes N*N RUN cycles with N = WIDTH/4.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b sampled in IDLE only)
//   a, b                 : WIDTH-bit unsigned operands
//   rom_addr / rom_data  : ROM lookup {a_nib[i], b_nib[j]} -> 8-bit product
//   out_valid / out_ready: result handshake
//   product              : 2*WIDTH-bit exact product, stable while out_valid
//
// Build option: define MUL_ZERO_SKIP_EN to bypass RUN when either operand is
// zero; the result goes straight to DONE with product 0.
module mant_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [7:0]           rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = nib_count(WIDTH);
  localparam int CW = $clog2(N);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  mul_state_t       state_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [CW-1:0]    i_reg, j_reg;
  logic [PW-1:0]    acc_reg;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    pp;
  logic             in_ready_reg, out_valid_reg;
  logic [PW-1:0]    product_reg;

  // Partial product for the current pair, aligned to nibble position i+j.
  always_comb begin
    pp       = PW'(rom_data) << (NIB_W * (int'(i_reg) + int'(j_reg)));
    acc_next = acc_reg + pp;
  end

  // Address is a pure decode of registered state, so it never depends on
  // the handshake inputs.
  always_comb begin
    rom_addr = 8'h00;
    if (state_reg == RUN) begin
      rom_addr = {a_reg[NIB_W*i_reg +: NIB_W], b_reg[NIB_W*j_reg +: NIB_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      product_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            acc_reg      <= '0;
            i_reg        <= '0;
            j_reg        <= '0;
            in_ready_reg <= 1'b0;
`ifdef MUL_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              product_reg   <= '0;
            end else begin
`else
            begin
`endif
              state_reg <= RUN;
            end
          end
        end

        RUN: begin
          acc_reg <= acc_next;
          if (j_reg == LAST_IDX) begin
            j_reg <= '0;
            if (i_reg == LAST_IDX) begin
              // Last pair: capture the finished sum directly.
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              product_reg   <= acc_next;
            end else begin
              i_reg <= i_reg + CW'(1);
            end
          end else begin
            j_reg <= j_reg + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed bench for mant_mul_seq (WIDTH=24) with the nibble-product ROM
// attached. Inputs change and outputs are sampled on the falling edge.
module tb_mant_mul_seq;

  localparam int WIDTH = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a_i;
  logic [WIDTH-1:0]  b_i;
  logic [7:0]        rom_addr;
  logic [7:0]        rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [7:0] addr_log [0:63];

  always #5 clk = ~clk;

  mant_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  rom256X8 rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle, then count falling edges until
  // out_valid (lat = 1 is the cycle right after acceptance). rom_addr is
  // logged at every counted edge.
  task automatic launch_and_wait(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    check("in_ready_before_launch", {63'd0, in_ready}, 64'd1);
    a_i = av;
    b_i = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    addr_log[1] = rom_addr;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat < 64) addr_log[lat] = rom_addr;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a_i = '0;
    b_i = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;

    // 1. all-ones operands, out_ready held high in advance
    launch_and_wait(24'hFFFFFF, 24'hFFFFFF);
    check("ones_latency", 64'(lat), 64'd37);
    check("ones_product", 64'(product), 64'hFFFFFE000001);
    check("done_rom_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    check("ones_one_cycle_done", {63'd0, out_valid}, 64'd0);
    check("ones_in_ready_after", {63'd0, in_ready}, 64'd1);
    $display("op ones: product=%h latency=%0d", product, lat);

    // 2. top bits only: exercises the largest shift
    launch_and_wait(24'h800000, 24'h800000);
    check("msb_product", 64'(product), 64'h400000000000);
    check("msb_addr_first", 64'(addr_log[1]), 64'h00);
    check("msb_addr_pair50", 64'(addr_log[31]), 64'h80);
    check("msb_addr_pair55", 64'(addr_log[36]), 64'h88);
    $display("op msb: product=%h latency=%0d", product, lat);

    // 3. output back-pressure for 10 cycles; new operands must be ignored
    @(negedge clk);
    out_ready = 1'b0;
    launch_and_wait(24'h123456, 24'h000001);
    check("hold_latency", 64'(lat), 64'd37);
    for (int k = 0; k < 10; k++) begin
      a_i = 24'hFFFFFF;
      b_i = 24'hFFFFFF;
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_product", 64'(product), 64'h000000123456);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    check("hold_out_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", {63'd0, out_valid}, 64'd0);
    check("hold_release_ready", {63'd0, in_ready}, 64'd1);
    $display("op hold: product=%h", product);

    // 4. zero operand
    launch_and_wait(24'h000000, 24'hABCDEF);
`ifdef MUL_ZERO_SKIP_EN
    check("zero_latency", 64'(lat), 64'd1);
    check("zero_rom_addr", 64'(addr_log[1]), 64'd0);
`else
    check("zero_latency", 64'(lat), 64'd37);
`endif
    check("zero_product", 64'(product), 64'd0);
    $display("op zero: product=%h latency=%0d", product, lat);
    @(negedge clk);

    // 5. reset in RUN cycle 20 aborts the operation
    @(negedge clk);
    a_i = 24'hFFFFFF;
    b_i = 24'hFFFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    launch_and_wait(24'h000003, 24'h000005);
    check("after_abort_latency", 64'(lat), 64'd37);
    check("after_abort_product", 64'(product), 64'h00000000000F);
    $display("op after_abort: product=%h latency=%0d", product, lat);
    @(negedge clk);

    // 6. back-to-back with in_valid held high
    @(negedge clk);
    a_i = 24'h000ABC;
    b_i = 24'h000010;
    in_valid = 1'b1;
    @(negedge clk);
    a_i = 24'h001234;
    b_i = 24'h000100;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 64'(lat), 64'd37);
    check("b2b_first_product", 64'(product), 64'h00000000ABC0);
    @(negedge clk);
    lat++;
    check("b2b_second_accept_cycle", 64'(lat), 64'd38);
    check("b2b_second_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 64'(lat), 64'd37);
    check("b2b_second_product", 64'(product), 64'h000000123400);
    $display("op b2b: product=%h latency=%0d", product, lat);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mant_mul_seq.md
# mant_mul_seq

Sequential unsigned mantissa multiplier for the multiplier component that drives the 256x8 nibble-product ROM (`rom256X8`). Each 8-bit ROM address is `{a_nibble, b_nibble}`, and the returned byte is their 4x4 product. The block iterates over all nibble pairs and accumulates the shifted partial products into a full-width product. It sits between operand unpacking (upstream) and normalisation/rounding (downstream), with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 24: operand width in bits (mantissa including hidden bit); must be a multiple of 4 and at least 8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `a`, `b` are valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: multiplicand, unsigned.
- `b` input WIDTH: multiplier, unsigned.
- `rom_addr` output 8: ROM address `{a_nib[i], b_nib[j]}`; `a_nib` is in bits 7:4.
- `rom_data` input 8: ROM output; combinational, valid in the same cycle as `rom_addr`.
- `out_valid` output 1: `product` is valid.
- `out_ready` input 1: downstream accepts `product`.
- `product` output 2*WIDTH: a*b, exact.

## Operation
- N = WIDTH/4 nibbles per operand. `a_nib[k]` = `a[4k+3:4k]`.
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch `a`, `b`; clear the accumulator; set i=0, j=0; go to RUN.
  - RUN: drive `rom_addr={a_nib[i], b_nib[j]}`. Each edge does `acc += rom_data << 4*(i+j)`.
    - j increments; when j wraps from N-1 to 0, i increments.
    - After the pair (N-1, N-1) is accumulated, go to DONE.
  - DONE: `out_valid`=1 and `product`=acc, held stable until `out_ready`. On `out_ready`, go to IDLE.
- Accumulator width is 2*WIDTH; it cannot overflow because (2^WIDTH-1)^2 < 2^(2*WIDTH).
- Operand inputs are ignored outside IDLE. There is no overlap of operations.
- `rom_addr` = 8'h00 outside RUN.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `rom_addr`=0, i=j=0.
- Reset asserted mid-RUN or in DONE aborts the operation and discards the result; the next cycle is IDLE.
- `rst` takes priority over all handshakes in the same cycle.

## Timing
- Handshake:
  - Input transfer occurs in cycle 0 (`in_valid` & `in_ready`).
  - RUN occupies cycles 1..N*N (36 for WIDTH=24).
  - `out_valid` rises in cycle N*N+1.
- Output transfer: `out_valid` & `out_ready`. The next `in_ready`=1 is in the following cycle, so the minimum input-to-input interval is N*N+2 cycles.
- `out_ready` may be held high in advance; DONE then lasts exactly one cycle.
- `in_ready` is a registered state decode. It does not depend combinationally on `in_valid` or `out_ready`.

## Configuration
- `MUL_ZERO_SKIP_EN`
  - Defined: at acceptance, if `a`==0 or `b`==0, skip RUN and go directly to DONE with `product`=0. `out_valid` rises in cycle 1, and `rom_addr` stays 0.
  - Undefined: zero operands take the full N*N RUN cycles. The result is identical; only latency differs.

## Structure
- Package `mul_pkg` holds:
  - the state enum `mul_state_t` (IDLE, RUN, DONE);
  - the constant `NIB_W`=4;
  - the function computing N from WIDTH.
- No sub-module. The ROM stays external so the same ROM instance serves the bench and the top level; the bench instantiates `rom256X8` and wires it to `rom_addr`/`rom_data`.

## Test plan
- `a`=24'hFFFFFF, `b`=24'hFFFFFF, `out_ready`=1 → `product`=48'hFFFFFE000001, `out_valid` exactly 37 cycles after acceptance.
- `a`=24'h800000, `b`=24'h800000 → `product`=48'h400000000000; `rom_addr` sequence starts 8'h00 and includes 8'h88 at pair (5,5).
- `a`=24'h123456, `b`=24'h000001 with `out_ready`=0 for 10 cycles → `product`=48'h000000123456 held stable; `in_ready`=0 and new `in_valid` ignored throughout.
- `a`=0, `b`=24'hABCDEF → `product`=0:
  - latency 1 cycle with `MUL_ZERO_SKIP_EN` defined;
  - latency 37 cycles without it.
- `rst` pulsed in RUN cycle 20 → next cycle `in_ready`=1 and `out_valid`=0. A following 24'h000003*24'h000005 returns 48'h00000000000F.
- Back-to-back: two operations with `in_valid` held high → second accepted in cycle N*N+2 after the first; both products correct.
